// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and legal width range.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle of the serial adder: operands and start in, status and result out.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/fa_using_hs.sv
// One-bit full adder composed from two half-adder stages.
module fa_using_hs (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic hs1_sum, hs1_carry, hs2_carry;

  assign hs1_sum   = a ^ b;
  assign hs1_carry = a & b;
  assign sum       = hs1_sum ^ c;
  assign hs2_carry = hs1_sum & c;
  assign carry     = hs1_carry | hs2_carry;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operand bits LSB first through a single full-adder cell,
// taking WIDTH cycles per addition and publishing sum/cout only on completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

  fa_using_hs u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // start is honoured in IDLE and DONE, never while shifting
  assign accept   = bus.start && (state_q != ST_SHIFT);
  assign last_bit = (cnt == LAST);

  // new sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
  always_comb begin
    s_next            = s_sh >> 1;
    s_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_d = last_bit  ? ST_DONE  : ST_SHIFT;
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ST_SHIFT);
    bus.done = (state_q == ST_DONE);
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= fa_carry;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        sum_q  <= s_next;
        cout_q <= fa_carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random vectors against an
// arithmetic reference, back-to-back, mid-operation reset, hold and WIDTH=1 cases.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {cout,sum} = a + b + cin, modulo 2^9
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // Issue one start on the 8-bit instance, scramble operands afterwards, wait for done.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output int nbusy, output int cyc);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = xa; bus8.b = xb; bus8.cin = xc;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    nbusy = 0;
    cyc   = 0;
    while (!bus8.done && cyc < 20) begin
      if (bus8.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc);
    int nb, cy;
    logic [8:0] r;
    r = ref_add(xa, xb, xc);
    run_op(xa, xb, xc, nb, cy);
    chk({tag, "_latency"}, cy, 8);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_done"}, int'(bus8.done), 1);
    chk({tag, "_sum"}, int'(bus8.sum), int'(r[7:0]));
    chk({tag, "_cout"}, int'(bus8.cout), int'(r[8]));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(bus8.done), 0);
    chk({tag, "_idle_after"}, int'(bus8.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dq[$];
    int k, saw;
    logic [1:0] r1;

    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sum: 8'h8D, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h01, b: 8'h02, cin: 1'b0, sum: 8'h03, cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h7F, cin: 1'b1, sum: 8'h00, cout: 1'b1};

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus8.busy), 0);
    chk("rst_done", int'(bus8.done), 0);
    chk("rst_sum", int'(bus8.sum), 0);
    chk("rst_cout", int'(bus8.cout), 0);
    chk("rst_w1_sum", int'(bus1.sum), 0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 5; i++) begin
      int nb, cy;
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, nb, cy);
      chk($sformatf("vec%0d_latency", i), cy, 8);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 8);
      chk($sformatf("vec%0d_done", i), int'(bus8.done), 1);
      chk($sformatf("vec%0d_sum", i), int'(bus8.sum), int'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), int'(bus8.cout), int'(vecs[i].cout));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), int'(bus8.done), 0);
      if (i == 0) begin
        // result must hold while idle regardless of input activity
        for (int j = 0; j < 20; j++) begin
          bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
          @(negedge clk);
          chk("hold_sum", int'(bus8.sum), int'(vecs[0].sum));
          chk("hold_cout", int'(bus8.cout), int'(vecs[0].cout));
          chk("hold_done", int'(bus8.done), 0);
        end
      end
    end

    // random vectors against the arithmetic reference
    for (int i = 0; i < 12; i++)
      check_op("rand", 8'($urandom), 8'($urandom), 1'($urandom));

    // start held high: re-accepted only in DONE, corrupting operands while shifting
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        dq.push_back(k);
        chk("held_sum", int'(bus8.sum), 'h30);
        chk("held_cout", int'(bus8.cout), 0);
      end
      if (bus8.done || !bus8.busy) begin
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
      end else begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      end
    end
    chk("held_count", dq.size(), 4);
    for (int i = 1; i < dq.size(); i++)
      chk("held_interval", dq[i] - dq[i-1], 9);
    bus8.start = 1'b0;
    k = 0;
    while ((bus8.busy || bus8.done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("held_drain_idle", int'(bus8.busy | bus8.done), 0);

    // reset in the middle of an operation
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", int'(bus8.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus8.busy), 0);
    chk("mid_rst_done", int'(bus8.done), 0);
    chk("mid_rst_sum", int'(bus8.sum), 0);
    chk("mid_rst_cout", int'(bus8.cout), 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) saw = 1;
    end
    chk("mid_rst_no_done", saw, 0);
    check_op("post_rst", 8'h01, 8'h02, 1'b0);

    // WIDTH=1 instance: exhaustive over a, b, cin
    for (int v = 7; v >= 0; v--) begin
      logic xa, xb, xc;
      xa = v[2]; xb = v[1]; xc = v[0];
      r1 = 2'(xa) + 2'(xb) + 2'(xc);
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = xa; bus1.b = xb; bus1.cin = xc;
      @(negedge clk);
      bus1.start = 1'b0; bus1.a = ~xa; bus1.b = ~xb; bus1.cin = ~xc;
      chk("w1_busy", int'(bus1.busy), 1);
      chk("w1_not_done_yet", int'(bus1.done), 0);
      @(negedge clk);
      chk("w1_done", int'(bus1.done), 1);
      chk("w1_sum", int'(bus1.sum), int'(r1[0]));
      chk("w1_cout", int'(bus1.cout), int'(r1[1]));
      @(negedge clk);
      chk("w1_done_pulse", int'(bus1.done), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
